// File: rtl/godai_data_mem_responder_if.sv
// Core data-port bundle (req/gnt/rvalid) between the core and its data memory.
// master = core side, slave = memory responder side.
interface godai_data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic                  data_we_i;
    logic [3:0]            data_be_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [31:0]           data_wdata_i;
    logic [31:0]           data_rdata_o;
    logic                  data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/godai_data_mem_responder.sv
// Data-memory responder: word memory with byte-enable stores, fixed-latency
// in-order responses and a bounded outstanding count with a grant-stall hook.
module godai_data_mem_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int RVALID_LATENCY  = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    godai_data_mem_responder_if.slave        bus,
    input  logic                             stall_i,
    output logic [3:0]                       outstanding_o
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

    logic [DATA_WIDTH-1:0]     mem_q [MEM_DEPTH_WORDS];

    logic [3:0]                outst_q, outst_d;
    logic [RVALID_LATENCY-1:0] pv_q;
    logic [RVALID_LATENCY-1:0] pe_q;
    logic [DATA_WIDTH-1:0]     pd_q [RVALID_LATENCY];

    logic [IDX_W-1:0]          word_idx;
    logic [MEM_AW-1:0]         mem_addr;
    logic                      in_range;
    logic                      gnt;
    logic                      accept;
    logic                      retire;
    logic                      wr_en;
    logic [DATA_WIDTH-1:0]     rd_word;

    assign word_idx = bus.data_addr_i[ADDR_WIDTH-1:2];
    assign mem_addr = word_idx[MEM_AW-1:0];
    assign in_range = (word_idx < IDX_W'(MEM_DEPTH_WORDS));

    // Grant looks only at the registered count, so retirement never feeds grant.
    assign gnt    = rst_n & bus.data_req_i & ~stall_i & (outst_q < 4'(MAX_OUTSTANDING));
    assign accept = gnt;
    assign retire = pv_q[RVALID_LATENCY-1];
    assign wr_en  = accept & bus.data_we_i & in_range;

    assign rd_word = (in_range && !bus.data_we_i) ? mem_q[mem_addr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be_i[b]) begin
                    mem_q[mem_addr][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Data only advances with a valid beat so the last stage holds the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pe_q <= '0;
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= accept;
            pe_q[0] <= accept & ~in_range;
            if (accept) begin
                pd_q[0] <= rd_word;
            end
            for (int i = 1; i < RVALID_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                if (pv_q[i-1]) begin
                    pd_q[i] <= pd_q[i-1];
                end
            end
        end
    end

    always_comb begin
        outst_d = outst_q;
        case ({accept, retire})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = pv_q[RVALID_LATENCY-1];
    assign bus.data_err_o    = pe_q[RVALID_LATENCY-1];
    assign bus.data_rdata_o  = pd_q[RVALID_LATENCY-1];
    assign outstanding_o     = outst_q;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.data_addr_i[1:0];

endmodule

// File: tb/tb_godai_data_mem_responder.sv
// Three responders (latency/limit 1/2, 3/4, 4/2) share one stimulus stream;
// a queue-based reference model is checked every cycle, plus literal spot checks.
module tb_godai_data_mem_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        req, we, stall;
    logic [3:0]  be;
    logic [31:0] addr, wdata;

    int n_vec = 0;
    int n_bad = 0;

    godai_data_mem_responder_if #(.ADDR_WIDTH(32)) if_a ();
    godai_data_mem_responder_if #(.ADDR_WIDTH(32)) if_b ();
    godai_data_mem_responder_if #(.ADDR_WIDTH(32)) if_c ();

    logic [3:0] os_a, os_b, os_c;

    assign if_a.data_req_i = req;   assign if_b.data_req_i = req;   assign if_c.data_req_i = req;
    assign if_a.data_we_i = we;     assign if_b.data_we_i = we;     assign if_c.data_we_i = we;
    assign if_a.data_be_i = be;     assign if_b.data_be_i = be;     assign if_c.data_be_i = be;
    assign if_a.data_addr_i = addr; assign if_b.data_addr_i = addr; assign if_c.data_addr_i = addr;
    assign if_a.data_wdata_i = wdata; assign if_b.data_wdata_i = wdata; assign if_c.data_wdata_i = wdata;

    godai_data_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH),
        .RVALID_LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .stall_i(stall), .outstanding_o(os_a));
    godai_data_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH),
        .RVALID_LATENCY(3), .MAX_OUTSTANDING(4)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .stall_i(stall), .outstanding_o(os_b));
    godai_data_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH),
        .RVALID_LATENCY(4), .MAX_OUTSTANDING(2)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c), .stall_i(stall), .outstanding_o(os_c));

    logic        gnt_w [3];
    logic        rv_w  [3];
    logic        err_w [3];
    logic [31:0] rd_w  [3];
    logic [3:0]  os_w  [3];
    assign gnt_w[0] = if_a.data_gnt_o;    assign gnt_w[1] = if_b.data_gnt_o;    assign gnt_w[2] = if_c.data_gnt_o;
    assign rv_w[0]  = if_a.data_rvalid_o; assign rv_w[1]  = if_b.data_rvalid_o; assign rv_w[2]  = if_c.data_rvalid_o;
    assign err_w[0] = if_a.data_err_o;    assign err_w[1] = if_b.data_err_o;    assign err_w[2] = if_c.data_err_o;
    assign rd_w[0]  = if_a.data_rdata_o;  assign rd_w[1]  = if_b.data_rdata_o;  assign rd_w[2]  = if_c.data_rdata_o;
    assign os_w[0]  = os_a;               assign os_w[1]  = os_b;               assign os_w[2]  = os_c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic int mos_of(input int k);
        return (k == 1) ? 4 : 2;
    endfunction

    function automatic logic [31:0] pre(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: each accept queues a response due LAT cycles later.
    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        er;
        bit          known;
    } resp_t;

    resp_t       mq   [3][$];
    logic [31:0] mmem [3][DEPTH];
    bit   [3:0]  mbv  [3][DEPTH];
    int          mout [3];
    bit          mrv  [3];
    bit          merr [3];
    bit          mknown [3];
    logic [31:0] mrd  [3];
    int          cyc;

    function automatic bit mgnt(input int k);
        return rst_n && req && !stall && (mout[k] < mos_of(k));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            mout[k] = 0; mrv[k] = 0; merr[k] = 0; mrd[k] = '0; mknown[k] = 1;
        end
    endtask

    initial begin
        resp_t r;
        bit    acc, ret, inr;
        int    idx;
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int k = 0; k < 3; k++) begin
                    acc = mgnt(k);
                    ret = mrv[k];
                    if (acc) begin
                        inr = (addr[31:2] < DEPTH);
                        idx = int'(addr[31:2]);
                        r.due = cyc + lat_of(k); r.er = !inr; r.rd = '0; r.known = 1;
                        if (inr && we) begin
                            for (int b = 0; b < 4; b++) begin
                                if (be[b]) begin
                                    mmem[k][idx][8*b +: 8] = wdata[8*b +: 8];
                                    mbv[k][idx][b] = 1'b1;
                                end
                            end
                        end else if (inr) begin
                            r.rd = mmem[k][idx];
                            r.known = &mbv[k][idx];
                        end
                        mq[k].push_back(r);
                    end
                    mout[k] = mout[k] + int'(acc) - int'(ret);
                end
                cyc++;
                for (int k = 0; k < 3; k++) begin
                    if (mq[k].size() > 0 && mq[k][0].due == cyc) begin
                        r = mq[k].pop_front();
                        mrv[k] = 1; mrd[k] = r.rd; merr[k] = r.er; mknown[k] = r.known;
                    end else begin
                        mrv[k] = 0; merr[k] = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("gnt[%0d]", k), 32'(gnt_w[k]), 32'(mgnt(k)));
                chk($sformatf("rvalid[%0d]", k), 32'(rv_w[k]), 32'(mrv[k]));
                chk($sformatf("err[%0d]", k), 32'(err_w[k]), 32'(merr[k]));
                chk($sformatf("outstanding[%0d]", k), 32'(os_w[k]), 32'(mout[k]));
                if (mknown[k]) chk($sformatf("rdata[%0d]", k), rd_w[k], mrd[k]);
            end
            chk("c_outstanding_le_2", 32'(os_c <= 4'd2), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit r, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 4'h0, 32'h0, 32'h0);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0;
        drv(1, 0, 4'hF, 32'h40, 32'h0);
        #1 rst_n = 1'b0;

        // reset: outputs quiet and no grant despite req high
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt_a", 32'(if_a.data_gnt_o), 32'd0);
            chk("rst_rvalid_a", 32'(if_a.data_rvalid_o), 32'd0);
            chk("rst_rdata_a", if_a.data_rdata_o, 32'h0);
            chk("rst_err_a", 32'(if_a.data_err_o), 32'd0);
            chk("rst_outst_a", 32'(os_a), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 16; i++) begin
            drv(1, 1, 4'hF, 32'(i * 4), pre(i));
            tick();
            idle(5);
        end
        drv(1, 1, 4'hF, 32'h80, 32'h1122_3344);
        tick();
        idle(5);

        // basic store then load, latency 1
        drv(1, 1, 4'hF, 32'h40, 32'hDEAD_BEEF);
        @(negedge clk); chk("basic_st_gnt", 32'(if_a.data_gnt_o), 32'd1);
        tick();
        drv(1, 0, 4'hF, 32'h40, 32'h0);
        @(negedge clk);
        chk("basic_ld_gnt", 32'(if_a.data_gnt_o), 32'd1);
        chk("basic_st_rvalid", 32'(if_a.data_rvalid_o), 32'd1);
        chk("basic_st_err", 32'(if_a.data_err_o), 32'd0);
        tick();
        drv(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("basic_ld_rvalid", 32'(if_a.data_rvalid_o), 32'd1);
        chk("basic_ld_rdata", if_a.data_rdata_o, 32'hDEAD_BEEF);
        chk("basic_ld_err", 32'(if_a.data_err_o), 32'd0);
        tick();
        @(negedge clk); chk("basic_rvalid_drop", 32'(if_a.data_rvalid_o), 32'd0);
        idle(6);

        // byte enables 0101 over 0x11223344
        drv(1, 1, 4'b0101, 32'h80, 32'hAABB_CCDD);
        tick();
        drv(1, 0, 4'hF, 32'h80, 32'h0);
        tick();
        drv(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("be_rvalid", 32'(if_a.data_rvalid_o), 32'd1);
        chk("be_rdata", if_a.data_rdata_o, 32'h11BB_33DD);
        idle(6);

        // back-to-back loads on the latency-3 / limit-4 instance
        for (int j = 0; j < 12; j++) begin
            if (j < 8) drv(1, 0, 4'hF, 32'(j * 4), 32'h0);
            else       drv(0, 0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            if (j < 8) chk($sformatf("b2b_gnt_%0d", j), 32'(if_b.data_gnt_o), 32'd1);
            if (j >= 3 && j < 11) begin
                chk($sformatf("b2b_rvalid_%0d", j), 32'(if_b.data_rvalid_o), 32'd1);
                chk($sformatf("b2b_rdata_%0d", j), if_b.data_rdata_o, pre(j - 3));
            end
            if (j == 11) chk("b2b_rvalid_end", 32'(if_b.data_rvalid_o), 32'd0);
            tick();
        end
        idle(10);

        // outstanding limit on latency-4 / limit-2: grants in cycles 0,1,5,6,10,11
        drv(1, 0, 4'hF, 32'h8, 32'h0);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("lim_gnt_%0d", j), 32'(if_c.data_gnt_o), 32'((j % 5) < 2));
            tick();
        end
        idle(12);

        // out-of-range load and store
        drv(1, 0, 4'hF, 32'h100, 32'h0);
        tick();
        drv(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("oor_rvalid", 32'(if_a.data_rvalid_o), 32'd1);
        chk("oor_err", 32'(if_a.data_err_o), 32'd1);
        chk("oor_rdata", if_a.data_rdata_o, 32'h0);
        idle(4);
        drv(1, 1, 4'hF, 32'h100, 32'hFFFF_FFFF);
        tick();
        idle(5);
        drv(1, 0, 4'hF, 32'h0, 32'h0);
        tick();
        drv(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("oor_st_nowrite", if_a.data_rdata_o, pre(0));
        idle(6);

        // stall with one response already in flight
        drv(1, 0, 4'hF, 32'h10, 32'h0);
        tick();
        stall = 1'b1;
        drv(1, 0, 4'hF, 32'h14, 32'h0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("stall_gnt_%0d", s), 32'(if_a.data_gnt_o), 32'd0);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stall_release_gnt_a", 32'(if_a.data_gnt_o), 32'd1);
        chk("stall_release_gnt_b", 32'(if_b.data_gnt_o), 32'd1);
        tick();
        idle(8);

        // reset mid-flight on the latency-4 instance
        drv(1, 0, 4'hF, 32'h4, 32'h0);
        tick();
        drv(1, 0, 4'hF, 32'h8, 32'h0);
        tick();
        drv(0, 0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mrst_gnt_c", 32'(if_c.data_gnt_o), 32'd0);
        chk("mrst_rvalid_c", 32'(if_c.data_rvalid_o), 32'd0);
        chk("mrst_rdata_c", if_c.data_rdata_o, 32'h0);
        chk("mrst_err_c", 32'(if_c.data_err_o), 32'd0);
        chk("mrst_outst_c", 32'(os_c), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("post_rst_rvalid_%0d", j), 32'(if_c.data_rvalid_o), 32'd0);
            tick();
        end
        drv(1, 0, 4'hF, 32'h4, 32'h0);
        @(negedge clk);
        chk("post_rst_gnt_c", 32'(if_c.data_gnt_o), 32'd1);
        tick();
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/godai_data_mem_responder.md
# godai_data_mem_responder

Responder (memory side) of the core's data memory req/gnt/rvalid interface: accepts load/store requests from the core's data port, holds a word-addressed on-chip memory with byte-enable writes, and returns exactly one in-order response per granted request after a fixed, parameterised latency. It sits in the Godai test/SoC top level, driving the core's data port inputs. Its latency, outstanding limit and stall input let the team exercise the core's data handshake under realistic memory behaviour.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; fixed 32 (4 byte lanes)
- MEM_DEPTH_WORDS, 1024, memory size in 32-bit words; power of two
- RVALID_LATENCY, 1, cycles from grant to rvalid; legal 1..8
- MAX_OUTSTANDING, 2, granted-but-unanswered limit; legal 1..15

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- data_req_i  in  1  request from core
- data_gnt_o  out  1  grant (combinational)
- data_rvalid_o  out  1  response valid, one cycle per granted request
- data_we_i  in  1  1 = store, 0 = load
- data_be_i  in  4  byte enables, bit n = byte lane n
- data_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  load data, valid with rvalid
- data_err_o  out  1  error flag, valid with rvalid
- stall_i  in  1  test hook: 1 suppresses grant
- outstanding_o  out  4  current outstanding count

## Operation
- Word index = data_addr_i[ADDR_WIDTH-1:2]; in range iff index < MEM_DEPTH_WORDS.
- data_gnt_o = rst_n & data_req_i & ~stall_i & (outstanding < MAX_OUTSTANDING). No combinational path from rvalid retirement into grant.
- Accept = req & gnt in a cycle; request fields sampled at that rising edge.
- Store, in range: bytes with be=1 written at accept edge; be=0 lanes unchanged; be=0000 writes nothing but still responds.
- Load, in range: full word read at accept edge (be ignored for reads; core extracts lanes).
- Out of range: no write; response rdata = 0, err = 1.
- Every accepted request (load or store) produces exactly one rvalid; responses strictly in accept order.
- Response pipeline: shift register of RVALID_LATENCY stages carrying {valid, err, rdata}; stage 0 loaded at accept edge, last stage drives outputs.
- Outstanding counter: +1 on accept, −1 on rvalid cycle; both in same cycle → unchanged. Never exceeds MAX_OUTSTANDING, never underflows.
- Memory contents not reset; bench writes before reading.

## Timing
- Accept in cycle T → data_rvalid_o high in cycle T+RVALID_LATENCY, for exactly one cycle.
- Full throughput (one accept per cycle) iff MAX_OUTSTANDING ≥ RVALID_LATENCY+1; otherwise grant deasserts when limit reached and reasserts the cycle after the count drops.
- Read-after-write: load accepted in cycle T+1 after store accepted in T returns the stored data.
- data_rdata_o holds its last response value while rvalid low; data_err_o is 0 whenever rvalid low.
- stall_i sampled combinationally; in-flight responses continue unaffected during stall.
- Reset values: data_rvalid_o 0, data_rdata_o 0, data_err_o 0, outstanding_o 0, data_gnt_o 0, pipeline valid bits 0.
- Reset asserted mid-transaction: all pending responses discarded (no rvalid after reset release), count cleared; memory writes already performed persist.
- Requests with req high and gnt low may change fields freely; no side effects until accept.

## Test plan
- Basic store/load, latency 1: store 0xDEADBEEF at 0x40 be=1111, then load 0x40 → rvalid exactly 1 cycle after each grant, second rdata = 0xDEADBEEF, err=0.
- Byte enables: preload 0x11223344 at 0x80; store 0xAABBCCDD be=0101; load → 0x11BB33DD.
- Back-to-back, RVALID_LATENCY=3, MAX_OUTSTANDING=4: 8 consecutive loads of addresses 0x0..0x1C with known data → grant every cycle, 8 consecutive rvalids starting 3 cycles after first grant, data in order.
- Outstanding limit, RVALID_LATENCY=4, MAX_OUTSTANDING=2: req held high → grants in cycles 0,1, then gnt low until count drops; outstanding_o never exceeds 2; each grant answered after 4 cycles.
- Error and stall: load at word index MEM_DEPTH_WORDS → rvalid with err=1, rdata=0; store out of range leaves memory unchanged; stall_i=1 for 5 cycles with req high → no grant, grant on first cycle after stall drops.
- Reset mid-flight, RVALID_LATENCY=4: 2 accepts, assert rst_n low 1 cycle later → all outputs 0 immediately, no rvalid after release, outstanding_o 0, first post-reset request granted normally.
